// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared state encoding, ALU opcodes and flag indices for the shift/ALU sequencer
package alu_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_EXEC  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/shift_alu_dp.sv
// rtl/shift_alu_dp.sv - combinational barrel shifter plus ALU with N/Z/C/V flags
//
// Ports:
//   shift_in, bshift, dir   -> shift_out   logical shift (dir 0 = left, 1 = right), zero fill
//   alu_a, alu_b, alu_ctrl  -> result      ADD/SUB/AND/OR/XOR, other opcodes give 0
//                           -> flags       {N,Z,C,V}
module shift_alu_dp
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] shift_in,
    input  logic [1:0]       bshift,
    input  logic             dir,
    output logic [WIDTH-1:0] shift_out,
    input  logic [WIDTH-1:0] alu_a,
    input  logic [WIDTH-1:0] alu_b,
    input  logic [2:0]       alu_ctrl,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    logic [WIDTH:0] sum;
    logic           carry;
    logic           ovf;

    assign shift_out = dir ? (shift_in >> bshift) : (shift_in << bshift);

    always_comb begin
        sum    = '0;
        result = '0;
        carry  = 1'b0;
        ovf    = 1'b0;
        case (alu_ctrl)
            OP_ADD: begin
                sum    = {1'b0, alu_a} + {1'b0, alu_b};
                result = sum[WIDTH-1:0];
                carry  = sum[WIDTH];
                ovf    = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (result[WIDTH-1] != alu_a[WIDTH-1]);
            end
            OP_SUB: begin
                // Two's-complement subtract; carry out of 1 means no borrow.
                sum    = {1'b0, alu_a} + {1'b0, ~alu_b} + (WIDTH+1)'(1);
                result = sum[WIDTH-1:0];
                carry  = sum[WIDTH];
                ovf    = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) && (result[WIDTH-1] != alu_a[WIDTH-1]);
            end
            OP_AND:  result = alu_a & alu_b;
            OP_OR:   result = alu_a | alu_b;
            OP_XOR:  result = alu_a ^ alu_b;
            default: result = '0;
        endcase

        flags         = '0;
        flags[FLAG_N] = result[WIDTH-1];
        flags[FLAG_Z] = (result == '0);
        flags[FLAG_C] = carry;
        flags[FLAG_V] = ovf;
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - multi-cycle shift-then-ALU sequencer with optional iteration
//
// Ports:
//   clk, reset                       clock, async active-high reset
//   cmd_valid/cmd_ready + cmd_*      command: operands, op, shift amount/direction, extra passes
//   rsp_valid/rsp_ready, rsp_result  final result and {N,Z,C,V} flags, held until taken
//   rsp_flags
//   busy                             high while shifting or executing
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int WIDTH  = 5,
    parameter int ITER_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [WIDTH-1:0]  cmd_a,
    input  logic [WIDTH-1:0]  cmd_b,
    input  logic [2:0]        cmd_alu_ctrl,
    input  logic [1:0]        cmd_bshift,
    input  logic              cmd_dir,
    input  logic [ITER_W-1:0] cmd_iter,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WIDTH-1:0]  rsp_result,
    output logic [3:0]        rsp_flags,
    output logic              busy
);

    state_t            state;
    state_t            next_state;
    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;
    logic [WIDTH-1:0]  sh_reg;
    logic [2:0]        op_reg;
    logic [1:0]        bshift_reg;
    logic              dir_reg;
    logic [ITER_W-1:0] cnt_reg;
    logic [3:0]        flags_reg;

    logic [WIDTH-1:0]  dp_shift;
    logic [WIDTH-1:0]  dp_result;
    logic [3:0]        dp_flags;

    // Shifter works on a_reg (SHIFT stage); ALU works on the registered shift (EXEC stage).
    shift_alu_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .shift_in  (a_reg),
        .bshift    (bshift_reg),
        .dir       (dir_reg),
        .shift_out (dp_shift),
        .alu_a     (sh_reg),
        .alu_b     (b_reg),
        .alu_ctrl  (op_reg),
        .result    (dp_result),
        .flags     (dp_flags)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (cmd_valid) next_state = ST_SHIFT;
            ST_SHIFT: next_state = ST_EXEC;
            ST_EXEC:  next_state = (cnt_reg == '0) ? ST_DONE : ST_SHIFT;
            ST_DONE:  if (rsp_ready) next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready  = 1'b0;
        busy       = 1'b0;
        rsp_valid  = 1'b0;
        rsp_result = '0;
        rsp_flags  = '0;
        case (state)
            ST_IDLE:  cmd_ready = 1'b1;
            ST_SHIFT: busy      = 1'b1;
            ST_EXEC:  busy      = 1'b1;
            ST_DONE: begin
                rsp_valid  = 1'b1;
                rsp_result = a_reg;
                rsp_flags  = flags_reg;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_reg      <= '0;
            b_reg      <= '0;
            sh_reg     <= '0;
            op_reg     <= '0;
            bshift_reg <= '0;
            dir_reg    <= 1'b0;
            cnt_reg    <= '0;
            flags_reg  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        a_reg      <= cmd_a;
                        b_reg      <= cmd_b;
                        op_reg     <= cmd_alu_ctrl;
                        bshift_reg <= cmd_bshift;
                        dir_reg    <= cmd_dir;
                        cnt_reg    <= cmd_iter;
                    end
                end
                ST_SHIFT: sh_reg <= dp_shift;
                ST_EXEC: begin
                    // Result feeds back as the next pass's A.
                    a_reg     <= dp_result;
                    flags_reg <= dp_flags;
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - ITER_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - directed and randomized scoreboard bench for alu_seq_ctrl
module tb_alu_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [4:0] cmd_a;
    logic [4:0] cmd_b;
    logic [2:0] cmd_alu_ctrl;
    logic [1:0] cmd_bshift;
    logic       cmd_dir;
    logic [1:0] cmd_iter;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [4:0] rsp_result;
    logic [3:0] rsp_flags;
    logic       busy;

    int checks = 0;
    int fails  = 0;
    logic [8:0] exp_q[$];

    alu_seq_ctrl #(.WIDTH(5), .ITER_W(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .cmd_alu_ctrl (cmd_alu_ctrl),
        .cmd_bshift   (cmd_bshift),
        .cmd_dir      (cmd_dir),
        .cmd_iter     (cmd_iter),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_flags    (rsp_flags),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sgn(input int v);
        return (v >= 16) ? v - 32 : v;
    endfunction

    // Reference: {result[4:0], N, Z, C, V} after iter+1 shift/op passes.
    function automatic logic [8:0] model(input int a, input int b, input int op,
                                         input int bs, input int dir, input int iter);
        int x, sh, s, r, c, v, sv;
        logic [8:0] out;
        x = a;
        r = 0; c = 0; v = 0;
        for (int p = 0; p <= iter; p++) begin
            sh = dir ? (x >> bs) : ((x << bs) % 32);
            c = 0; v = 0;
            case (op)
                0: begin
                    s = sh + b; r = s % 32; c = (s >= 32);
                    sv = sgn(sh) + sgn(b); v = (sv > 15 || sv < -16);
                end
                1: begin
                    s = sh + (31 - b) + 1; r = s % 32; c = (s >= 32);
                    sv = sgn(sh) - sgn(b); v = (sv > 15 || sv < -16);
                end
                2: r = sh & b;
                3: r = sh | b;
                4: r = sh ^ b;
                default: r = 0;
            endcase
            x = r;
        end
        out[8:4] = r[4:0];
        out[3]   = (r >= 16);
        out[2]   = (r == 0);
        out[1]   = c[0];
        out[0]   = v[0];
        return out;
    endfunction

    task automatic send_cmd(input logic [4:0] a, input logic [4:0] b, input logic [2:0] op,
                            input logic [1:0] bs, input logic dir, input logic [1:0] iter);
        int guard = 0;
        @(negedge clk);
        while (!cmd_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("cmd_ready_before_accept", 16'(cmd_ready), 16'd1);
        cmd_a = a; cmd_b = b; cmd_alu_ctrl = op;
        cmd_bshift = bs; cmd_dir = dir; cmd_iter = iter;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    // Called at accept edge + 1; counts edges until rsp_valid and busy samples along the way.
    task automatic wait_rsp(input int exp_lat);
        int lat = 0;
        int busy_cnt = 0;
        while (!rsp_valid && lat < 20) begin
            if (busy) busy_cnt++;
            @(posedge clk);
            #1;
            lat++;
        end
        check("rsp_latency", 16'(lat), 16'(exp_lat));
        check("busy_cycles", 16'(busy_cnt), 16'(exp_lat));
    endtask

    task automatic finish_rsp(input int hold, input logic poke_cmd);
        logic [4:0] r0;
        logic [3:0] f0;
        logic [8:0] exp;
        r0 = rsp_result;
        f0 = rsp_flags;
        if (poke_cmd) begin
            cmd_a = 5'd9; cmd_b = 5'd1; cmd_alu_ctrl = 3'd0;
            cmd_bshift = 2'd0; cmd_dir = 1'b0; cmd_iter = 2'd0;
            cmd_valid = 1'b1;
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_valid", 16'(rsp_valid), 16'd1);
            check("hold_result", 16'(rsp_result), 16'(r0));
            check("hold_flags", 16'(rsp_flags), 16'(f0));
            check("hold_cmd_ready", 16'(cmd_ready), 16'd0);
        end
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 16'd1, 16'd0);
            exp = 9'd0;
        end else begin
            exp = exp_q.pop_front();
        end
        check("rsp_result_flags", 16'({rsp_result, rsp_flags}), 16'(exp));
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("idle_after_rsp_valid", 16'(rsp_valid), 16'd0);
        check("idle_after_rsp_ready", 16'(cmd_ready), 16'd1);
        if (poke_cmd) begin
            check("no_accept_on_rsp_edge", 16'(busy), 16'd0);
            cmd_valid = 1'b0;
        end
    endtask

    initial begin
        int seen;
        reset = 1'b1;
        cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_a = '0; cmd_b = '0; cmd_alu_ctrl = '0; cmd_bshift = '0; cmd_dir = 1'b0; cmd_iter = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_rsp_valid", 16'(rsp_valid), 16'd0);
        check("reset_busy", 16'(busy), 16'd0);
        check("reset_result", 16'(rsp_result), 16'd0);
        check("reset_flags", 16'(rsp_flags), 16'd0);
        check("reset_cmd_ready", 16'(cmd_ready), 16'd1);
        @(negedge clk);
        reset = 1'b0;

        // ADD 3<<1 + 1 = 7
        exp_q.push_back({5'd7, 4'b0000});
        send_cmd(5'd3, 5'd1, 3'd0, 2'd1, 1'b0, 2'd0);
        wait_rsp(2);
        finish_rsp(0, 1'b0);

        // SUB 2 - 3 = 31 with borrow
        exp_q.push_back({5'd31, 4'b1000});
        send_cmd(5'd2, 5'd3, 3'd1, 2'd0, 1'b0, 2'd0);
        wait_rsp(2);
        finish_rsp(0, 1'b0);

        // ADD overflow 14 + 5 = 19
        exp_q.push_back({5'd19, 4'b1001});
        send_cmd(5'd7, 5'd5, 3'd0, 2'd1, 1'b0, 2'd0);
        wait_rsp(2);
        finish_rsp(1, 1'b0);

        // Four passes: 2, 4, 8, 16
        exp_q.push_back({5'd16, 4'b1000});
        send_cmd(5'd1, 5'd0, 3'd0, 2'd1, 1'b0, 2'd3);
        wait_rsp(8);
        finish_rsp(0, 1'b0);

        // XOR to zero with 3 cycles of backpressure and a command waiting
        exp_q.push_back({5'd0, 4'b0100});
        send_cmd(5'd5, 5'd5, 3'd4, 2'd0, 1'b0, 2'd0);
        wait_rsp(2);
        finish_rsp(3, 1'b1);

        // Abort an iter=2 command in EXEC
        send_cmd(5'd6, 5'd2, 3'd0, 2'd1, 1'b0, 2'd2);
        @(posedge clk);
        #1;
        check("pre_abort_busy", 16'(busy), 16'd1);
        reset = 1'b1;
        #1;
        check("abort_busy", 16'(busy), 16'd0);
        check("abort_rsp_valid", 16'(rsp_valid), 16'd0);
        check("abort_result", 16'(rsp_result), 16'd0);
        check("abort_flags", 16'(rsp_flags), 16'd0);
        check("abort_cmd_ready", 16'(cmd_ready), 16'd1);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (rsp_valid) seen = 1;
        end
        check("no_rsp_after_abort", 16'(seen), 16'd0);

        // Right shift 24 >> 3 = 3, OR 0
        exp_q.push_back({5'd3, 4'b0000});
        send_cmd(5'd24, 5'd0, 3'd3, 2'd3, 1'b1, 2'd0);
        wait_rsp(2);
        finish_rsp(0, 1'b0);

        // Randomized commands against the reference model
        for (int k = 0; k < 16; k++) begin
            logic [4:0] ra, rb;
            logic [2:0] rop;
            logic [1:0] rbs, rit;
            logic       rdir;
            ra   = 5'($urandom_range(0, 31));
            rb   = 5'($urandom_range(0, 31));
            rop  = 3'($urandom_range(0, 7));
            rbs  = 2'($urandom_range(0, 3));
            rdir = 1'($urandom_range(0, 1));
            rit  = 2'($urandom_range(0, 3));
            exp_q.push_back(model(int'(ra), int'(rb), int'(rop), int'(rbs), int'(rdir), int'(rit)));
            send_cmd(ra, rb, rop, rbs, rdir, rit);
            wait_rsp(2 * (int'(rit) + 1));
            finish_rsp(int'($urandom_range(0, 2)), 1'b0);
        end

        check("scoreboard_drained", 16'(exp_q.size()), 16'd0);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Multi-cycle sequencer for the 5-bit shift + ALU datapath: barrel shift of operand A (left/right), then ALU op against B.
- Accepts one command per transaction on a valid/ready interface and registers both stages.
- Optionally iterates the op 1–4 times, feeding each result back as the next A.
- Returns the final result and flags on a valid/ready response interface.
- Sits between the instruction/test front-end and the combinational shift/ALU datapath.

Parameters:
- WIDTH, 5, datapath width of A, B and result.
- ITER_W, 2, width of the iteration count; passes = cmd_iter + 1.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  controller can accept a command (high only in IDLE)
- cmd_a  input  WIDTH  initial operand A
- cmd_b  input  WIDTH  operand B, constant for all passes
- cmd_alu_ctrl  input  3  ALU op: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR; 101–111 give result 0 and flags 0100
- cmd_bshift  input  2  shift amount 0–3
- cmd_dir  input  1  0 = logical shift left, 1 = logical shift right
- cmd_iter  input  ITER_W  number of extra passes
- rsp_valid  output  1  result available
- rsp_ready  input  1  consumer takes result
- rsp_result  output  WIDTH  final result
- rsp_flags  output  4  {N,Z,C,V} of the final pass
- busy  output  1  high in SHIFT or EXEC

Behaviour:
- Reset (async, active-high):
  - state = IDLE.
  - All internal registers, rsp_result and rsp_flags = 0.
  - rsp_valid = 0, busy = 0; cmd_ready = 1 once in IDLE.
  - Reset asserted mid-operation aborts the transaction; no response is produced.
- States: IDLE, SHIFT, EXEC, DONE.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid at an edge: latch a, b, alu_ctrl, bshift, dir, iter; pass counter = iter; go to SHIFT.
- SHIFT: sh_reg <= shift(a_reg, bshift, dir); go to EXEC.
  - Bits shifted out are discarded; shifted-in bits are 0.
  - bshift = 0 passes A unchanged.
- EXEC: a_reg <= ALU(sh_reg, b_reg); flags_reg <= flags.
  - If counter == 0, go to DONE.
  - Otherwise decrement the counter and go to SHIFT.
- DONE:
  - rsp_valid = 1; rsp_result = a_reg and rsp_flags = flags_reg, held stable.
  - On rsp_ready, go to IDLE.
  - No command is accepted in the same cycle as the response handshake.
- Latency: rsp_valid rises 2*(iter+1) clock edges after the accepting edge (2 edges minimum, 8 maximum).
- Arithmetic: WIDTH-bit modular arithmetic.
  - N = result MSB; Z = (result == 0).
  - ADD: C = carry out; V = signed overflow.
  - SUB: computed as A + ~B + 1; C = carry out (1 = no borrow); V = signed overflow.
  - Logic ops: C = 0, V = 0.
- cmd inputs are ignored outside IDLE; rsp_ready is ignored outside DONE.

Decomposition:
- Shared package alu_seq_pkg holds:
  - state encoding (IDLE = 0, SHIFT = 1, EXEC = 2, DONE = 3);
  - ALU opcode constants;
  - flag bit indices (N = 3, Z = 2, C = 1, V = 0).
- One combinational sub-module, shift_alu_dp: shifter, direction mux, ALU and flag logic.
- alu_seq_ctrl contains only the FSM, operand/result registers and the pass counter.

Test Plan:
- ADD, a=3, b=1, bshift=1, dir=0, iter=0 -> rsp_valid 2 edges after accept; result 7, flags 0000; busy high for exactly 2 cycles.
- SUB, a=2, b=3, bshift=0, iter=0 -> result 31, flags 1000 (N=1, C=0 borrow).
- ADD overflow: a=7, bshift=1 left (A becomes 14), b=5 -> result 19 (10011), flags 1001.
- Iterate: ADD, a=1, b=0, bshift=1 left, iter=3 -> A sequence 2, 4, 8, 16; result 16, flags 1000; rsp_valid exactly 8 edges after accept.
- Backpressure: XOR, a=5, b=5, iter=0 with rsp_ready held low 3 cycles -> result 0, flags 0100; result and flags stable while waiting; cmd_ready = 0 throughout; IDLE one edge after rsp_ready.
- Reset mid-EXEC of an iter=2 command -> outputs return to 0 immediately and no rsp_valid pulse. A fresh right-shift command (a=24, bshift=3, dir=1, OR b=0) -> result 3, flags 0000.
